// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter and the processor control path.
// Holds FSM encodings, requester IDs and default bus widths.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 26;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic ARB_PORT_IF = 1'b0;
  localparam logic ARB_PORT_LS = 1'b1;

  // Processor control-unit states; the control FSM raises arbiter requests.
  typedef enum logic [2:0] {
    CPU_FETCH     = 3'd0,
    CPU_DECODE    = 3'd1,
    CPU_EXECUTE   = 3'd2,
    CPU_MEM       = 3'd3,
    CPU_WRITEBACK = 3'd4
  } cpu_state_e;

  function automatic logic arb_other_port(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W
);

  logic                  IF_REQ;
  logic [ADDR_WIDTH-1:0] IF_ADDR;
  logic                  IF_ACK;
  logic [DATA_WIDTH-1:0] IF_RDATA;
  logic                  LS_REQ;
  logic                  LS_WE;
  logic [ADDR_WIDTH-1:0] LS_ADDR;
  logic [DATA_WIDTH-1:0] LS_WDATA;
  logic                  LS_ACK;
  logic [DATA_WIDTH-1:0] LS_RDATA;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [DATA_WIDTH-1:0] MEM_WDATA;
  logic [DATA_WIDTH-1:0] MEM_RDATA;
  logic                  BUSY;

  modport master (
    output IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, MEM_RDATA,
    input  IF_ACK, IF_RDATA, LS_ACK, LS_RDATA,
    input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, BUSY
  );

  modport slave (
    input  IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, MEM_RDATA,
    output IF_ACK, IF_RDATA, LS_ACK, LS_RDATA,
    output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, BUSY
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker between fetch and load/store.
// On a tie the port that did not win last time is chosen.
module arb_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic IF_REQ,
  input  logic LS_REQ,
  input  logic LAST,
  output logic GRANT_VALID,
  output logic GRANT_ID
);

  always_comb begin
    GRANT_VALID = IF_REQ | LS_REQ;
    GRANT_ID    = ARB_PORT_IF;
    if (IF_REQ && LS_REQ) begin
      GRANT_ID = arb_other_port(LAST);
    end else if (LS_REQ) begin
      GRANT_ID = ARB_PORT_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// holding each strobe for MEM_LAT cycles and acknowledging with a one-cycle pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W,
  parameter int MEM_LAT    = 2
)(
  input  logic CLK,
  input  logic RST,
  mem_port_arbiter_if.slave bus
);

  // MEM_LAT is limited to 1..15 so the access counter fits in four bits.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  arb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  grant_valid;
  logic                  grant_id;

  arb_rr_pick2 u_pick (
    .IF_REQ      (bus.IF_REQ),
    .LS_REQ      (bus.LS_REQ),
    .LAST        (last_q),
    .GRANT_VALID (grant_valid),
    .GRANT_ID    (grant_id)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      last_q     <= ARB_PORT_LS;
      port_q     <= ARB_PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d = ARB_ACCESS;
          cnt_d   = '0;
          last_d  = grant_id;
          port_d  = grant_id;
          // Fetches are always reads; snapshot the request so later input changes are ignored.
          if (grant_id == ARB_PORT_LS) begin
            we_d    = bus.LS_WE;
            addr_d  = bus.LS_ADDR;
            wdata_d = bus.LS_WDATA;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.IF_ADDR;
            wdata_d = '0;
          end
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == LAT_LAST) begin
          state_d = ARB_DONE;
          cnt_d   = '0;
          if (!we_q) begin
            if (port_q == ARB_PORT_LS) begin
              ls_rdata_d = bus.MEM_RDATA;
            end else begin
              if_rdata_d = bus.MEM_RDATA;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so an async reset clears them at once.
  always_comb begin
    bus.MEM_READ  = 1'b0;
    bus.MEM_WRITE = 1'b0;
    bus.MEM_ADDR  = '0;
    bus.MEM_WDATA = '0;
    bus.IF_ACK    = 1'b0;
    bus.LS_ACK    = 1'b0;
    bus.IF_RDATA  = if_rdata_q;
    bus.LS_RDATA  = ls_rdata_q;
    bus.BUSY      = (state_q != ARB_IDLE);
    if (state_q == ARB_ACCESS) begin
      bus.MEM_READ  = !we_q;
      bus.MEM_WRITE = we_q;
      bus.MEM_ADDR  = addr_q;
      bus.MEM_WDATA = wdata_q;
    end
    if (state_q == ARB_DONE) begin
      bus.IF_ACK = (port_q == ARB_PORT_IF);
      bus.LS_ACK = (port_q == ARB_PORT_LS);
    end
  end

endmodule
